es_shift_sequencer: RTL and testbench
=====================================

Name: es_shift_sequencer

Overview:
Multi-cycle controller that drives the team's 32-bit extend/shift unit (modes: sign-extend-low, zero-extend-low, high-zero-fill, left-shift by 0..3).
Accepts one operation at a time over a valid/ready request channel.
Performs immediate extension in a single pass, or arbitrary left shifts of 0..31 by iterating the unit's 0..3-bit shift mode.
Returns the result on a valid/ready response channel. Sits between decode/issue and the writeback mux.

Parameters:
MAX_STEP, 3, max shift per pass sent to the unit; legal 1..3.
SHAMT_W, 5, width of the requested shift amount.

Ports:
CLK  input  1  clock, all state updates on rising edge
RSTN  input  1  synchronous active-low reset
REQ_VALID  input  1  request present
REQ_READY  output  1  sequencer can accept a request
REQ_OP  input  2  0=ELOS (sign-extend low), 1=ELOU (zero-extend low), 2=EHIZ (imm to high half), 3=SLL
REQ_A  input  32  shift operand (SLL only)
REQ_IMM  input  16  immediate (ops 0..2)
REQ_SHAMT  input  SHAMT_W  total left-shift amount (SLL only)
RSP_VALID  output  1  result valid
RSP_READY  input  1  consumer takes result
RSP_DATA  output  32  result
BUSY  output  1  high in any state other than IDLE
ES_SEL  output  2  mode select to extend/shift unit
ES_A  output  32  operand A to unit
ES_B  output  16  operand B to unit; bits [1:0] carry the shift step in SLL
ES_S  input  32  combinational result from unit

Behaviour:
- One clock (CLK). Reset is synchronous, active-low (RSTN sampled on the CLK rising edge).
- Reset values: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_DATA=0, BUSY=0, ES_SEL=0, ES_A=0, ES_B=0, internal acc/remaining=0.
- RSTN low in any state, including mid-shift or while RSP_VALID is high, aborts the operation. The result is discarded; there is no partial response.
- FSM states: IDLE, EXT, SHIFT, DONE.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY:
  - latch op, A, IMM and SHAMT;
  - set rem=SHAMT and acc=A;
  - go to SHIFT if op==3, else EXT.
- EXT (one cycle):
  - ES_SEL=op, ES_B=latched IMM, ES_A=0.
  - At the edge: RSP_DATA<=ES_S, go to DONE.
- SHIFT:
  - ES_SEL=3, ES_A=acc, ES_B={14'd0, step}, where step=min(rem, MAX_STEP).
  - At each edge: acc<=ES_S, rem<=rem-step.
  - When the new rem is 0, also RSP_DATA<=ES_S and go to DONE.
  - SHAMT=0 takes exactly one pass with step=0, so the result equals A.
  - Pass count = max(1, ceil(SHAMT/MAX_STEP)). Shift results are mod 2^32; bits shifted out are lost.
- DONE:
  - RSP_VALID=1; RSP_DATA held stable until RSP_READY.
  - On RSP_READY, go to IDLE.
  - REQ_READY=0 (default build).
- Latency from accept edge to RSP_VALID high:
  - extend ops: 2 cycles;
  - SLL: 1 + passes cycles (SHAMT=31, MAX_STEP=3: 12 cycles).
- Default-build throughput: one op per (latency + 1) cycles, plus any response stall.
- ES_* outputs are 0 in IDLE and DONE.
- Request inputs are ignored when REQ_READY=0. The sequencer never asserts RSP_VALID without a prior accepted request.

Optional Feature:
ES_SEQ_PIPE_EN
- Defined: in DONE, REQ_READY=RSP_READY. A simultaneous response handshake and request accept goes directly to EXT/SHIFT with the new request latched, skipping IDLE.
  - Back-to-back extend ops then sustain one result per 2 cycles.
  - RSP_VALID drops for the next operation's execution cycles.
- Undefined: REQ_READY is high only in IDLE, as specified above.

Test Plan:
- ELOS, IMM=16'h8000 -> RSP_VALID 2 cycles after accept, RSP_DATA=32'hFFFF8000. ELOU same IMM -> 32'h00008000.
- EHIZ, IMM=16'h1234 -> RSP_DATA=32'h12340000. ES_SEL=2 observed for exactly one cycle.
- SLL, A=32'h00000001, SHAMT=31 -> 11 SHIFT passes with steps 3×10 then 1; RSP_DATA=32'h80000000 at accept+12.
- SLL, A=32'hDEADBEEF, SHAMT=0 -> one pass with ES_B=0, RSP_DATA=32'hDEADBEEF. SHAMT=4 -> 32'hEADBEEF0 after steps 3,1.
- Backpressure: RSP_READY low 5 cycles in DONE -> RSP_VALID and RSP_DATA stable, REQ_READY=0, BUSY=1. Then RSP_READY=1 -> IDLE next cycle. With ES_SEQ_PIPE_EN, a new REQ_VALID on that handshake cycle is accepted.
- RSTN low for one cycle during SHIFT pass 5 of SHAMT=31 -> next cycle IDLE, RSP_VALID=0, RSP_DATA=0, no response emitted. A following request completes normally.

Source files
------------

// File: rtl/es_shift_sequencer.sv
// es_shift_sequencer
// Multi-cycle controller for the 32-bit extend/shift unit. Extend ops take a
// single pass through the unit. SLL by 0..31 is built from repeated passes of
// the unit's 0..3-bit left-shift mode.
//
// Build option: define ES_SEQ_PIPE_EN so that a new request can be accepted
// in the same cycle as the response handshake. This skips IDLE between ops.
// Without the macro, REQ_READY is high only in IDLE.
//
// All FSM outputs are registered. They are loaded on the edge that enters a
// state, so ES_SEL/ES_A/ES_B are already valid during the first execution
// cycle. ES_S comes back combinationally within that same cycle.

module es_shift_sequencer #(
  parameter int MAX_STEP = 3,   // max shift per unit pass, 1..3
  parameter int SHAMT_W  = 5    // width of requested shift amount
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [1:0]         REQ_OP,
  input  logic [31:0]        REQ_A,
  input  logic [15:0]        REQ_IMM,
  input  logic [SHAMT_W-1:0] REQ_SHAMT,
  output logic               RSP_VALID,
  input  logic               RSP_READY,
  output logic [31:0]        RSP_DATA,
  output logic               BUSY,
  output logic [1:0]         ES_SEL,
  output logic [31:0]        ES_A,
  output logic [15:0]        ES_B,
  input  logic [31:0]        ES_S
);

  // Operation encodings, shared with the unit's mode select.
  localparam logic [1:0] OP_ELOS = 2'd0;
  localparam logic [1:0] OP_SLL  = 2'd3;

  localparam logic [1:0]         MAX_STEP_L = 2'(MAX_STEP);
  localparam logic [SHAMT_W-1:0] MAX_STEP_W = SHAMT_W'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXT   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [31:0]        acc;      // running shifted value
  logic [SHAMT_W-1:0] rem;      // shift still to be applied
  logic               ready_q;  // registered "idle and accepting"

  // Per-pass step: the remaining amount, capped at MAX_STEP. A remaining
  // amount of 0 gives step 0. SHAMT=0 still makes one pass and returns A.
  function automatic logic [1:0] step_of(input logic [SHAMT_W-1:0] r);
    logic [1:0] s;
    if (r < MAX_STEP_W) s = r[1:0];
    else                s = MAX_STEP_L;
    return s;
  endfunction

  logic [1:0]         cur_step;
  logic [SHAMT_W-1:0] rem_next;
  logic [1:0]         next_step;

  // Step bookkeeping for the pass now in flight and for the pass after it.
  always_comb begin
    cur_step  = step_of(rem);
    rem_next  = rem - SHAMT_W'(cur_step);
    next_step = step_of(rem_next);
  end

  // Request acceptance. In the pipelined build, DONE also takes a request,
  // but only when the response handshake completes in the same cycle.
`ifdef ES_SEQ_PIPE_EN
  assign REQ_READY = ready_q | ((state == DONE) & RSP_READY);
`else
  assign REQ_READY = ready_q;
`endif

  logic accept;
  assign accept = REQ_VALID & REQ_READY;

  // Launch values for a newly accepted request: the first-cycle unit drive
  // and the state to enter. ES_SEL/ES_B hold the latched op and immediate
  // for the whole EXT cycle, so no separate copies are kept.
  state_t      launch_state;
  logic [1:0]  launch_sel;
  logic [31:0] launch_a;
  logic [15:0] launch_b;

  always_comb begin
    launch_state = EXT;
    launch_sel   = REQ_OP;
    launch_a     = 32'd0;
    launch_b     = REQ_IMM;
    if (REQ_OP == OP_SLL) begin
      launch_state = SHIFT;
      launch_sel   = OP_SLL;
      launch_a     = REQ_A;
      launch_b     = {14'd0, step_of(REQ_SHAMT)};
    end
  end

  // Main FSM with all outputs registered. A synchronous reset aborts any op
  // in flight, including a pending response, with no partial result.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 32'd0;
      BUSY      <= 1'b0;
      ES_SEL    <= OP_ELOS;
      ES_A      <= 32'd0;
      ES_B      <= 16'd0;
      acc       <= 32'd0;
      rem       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= launch_state;
            ready_q <= 1'b0;
            BUSY    <= 1'b1;
            ES_SEL  <= launch_sel;
            ES_A    <= launch_a;
            ES_B    <= launch_b;
            acc     <= REQ_A;
            rem     <= REQ_SHAMT;
          end
        end

        // Single pass: the unit output is the final result.
        EXT: begin
          state     <= DONE;
          RSP_DATA  <= ES_S;
          RSP_VALID <= 1'b1;
          ES_SEL    <= OP_ELOS;
          ES_A      <= 32'd0;
          ES_B      <= 16'd0;
        end

        // One unit pass per cycle. Feed each result back as the next operand
        // until the remaining amount reaches 0.
        SHIFT: begin
          acc <= ES_S;
          rem <= rem_next;
          if (rem_next == '0) begin
            state     <= DONE;
            RSP_DATA  <= ES_S;
            RSP_VALID <= 1'b1;
            ES_SEL    <= OP_ELOS;
            ES_A      <= 32'd0;
            ES_B      <= 16'd0;
          end else begin
            ES_A <= ES_S;
            ES_B <= {14'd0, next_step};
          end
        end

        // Hold the result until the consumer takes it. In the default build,
        // accept cannot be high here because ready_q is low.
        DONE: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            if (accept) begin
              state  <= launch_state;
              BUSY   <= 1'b1;
              ES_SEL <= launch_sel;
              ES_A   <= launch_a;
              ES_B   <= launch_b;
              acc    <= REQ_A;
              rem    <= REQ_SHAMT;
            end else begin
              state   <= IDLE;
              ready_q <= 1'b1;
              BUSY    <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_es_shift_sequencer.sv
// Directed bench for es_shift_sequencer. It includes a behavioural model of
// the extend/shift unit, which closes the ES_* loop. Cycle numbering: the
// cycle in which the request handshake is presented is cycle 0, so
// RSP_VALID is first seen high in cycle 2 for extend ops.

module tb_es_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_OP;
  logic [31:0] REQ_A;
  logic [15:0] REQ_IMM;
  logic [4:0]  REQ_SHAMT;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        BUSY;
  logic [1:0]  ES_SEL;
  logic [31:0] ES_A;
  logic [15:0] ES_B;
  logic [31:0] ES_S;

  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] steps_q[$];

  es_shift_sequencer #(.MAX_STEP(3), .SHAMT_W(5)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_IMM(REQ_IMM), .REQ_SHAMT(REQ_SHAMT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .BUSY(BUSY), .ES_SEL(ES_SEL), .ES_A(ES_A), .ES_B(ES_B), .ES_S(ES_S)
  );

  always #5 CLK = ~CLK;

  // Extend/shift unit model
  always_comb begin
    case (ES_SEL)
      2'd0:    ES_S = {{16{ES_B[15]}}, ES_B};
      2'd1:    ES_S = {16'd0, ES_B};
      2'd2:    ES_S = {ES_B, 16'd0};
      default: ES_S = ES_A << ES_B[1:0];
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request and pass the accept edge. On return, we are in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [15:0] imm, input logic [4:0] shamt);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_A = a; REQ_IMM = imm; REQ_SHAMT = shamt;
    chk("req_ready_before_accept", 32'(REQ_READY), 32'd1);
    tick();
    REQ_VALID = 1'b0;
  endtask

  // Run one op to completion. This checks latency (cycle of first
  // RSP_VALID), the number of execution cycles showing exp_sel on ES_SEL,
  // and the result. It records ES_B of every SLL pass into steps_q.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [15:0] imm, input logic [4:0] shamt,
                        input logic [31:0] exp_data, input int exp_lat,
                        input int exp_sel_cycles, input logic [1:0] exp_sel);
    int lat;
    int sel_cycles;
    RSP_READY = 1'b0;
    steps_q.delete();
    issue(op, a, imm, shamt);
    lat = 1;
    sel_cycles = 0;
    while (!RSP_VALID && lat < 40) begin
      if (ES_SEL == exp_sel) sel_cycles++;
      if (op == 2'd3) steps_q.push_back(ES_B);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_sel_cycles"}, 32'(sel_cycles), 32'(exp_sel_cycles));
    chk({tag, "_data"}, RSP_DATA, exp_data);
    chk({tag, "_es_sel_done"}, 32'(ES_SEL), 32'd0);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk({tag, "_idle_valid"}, 32'(RSP_VALID), 32'd0);
    chk({tag, "_idle_ready"}, 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    int vcount;
    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_OP = 2'd0; REQ_A = 32'd0;
    REQ_IMM = 16'd0; REQ_SHAMT = 5'd0; RSP_READY = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", RSP_DATA, 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_es_sel", 32'(ES_SEL), 32'd0);
    chk("rst_es_a", ES_A, 32'd0);
    chk("rst_es_b", 32'(ES_B), 32'd0);
    RSTN = 1'b1;
    tick();

    // ELOS 8000 with a 5-cycle response stall
    issue(2'd0, 32'd0, 16'h8000, 5'd0);
    chk("elos_c1_valid", 32'(RSP_VALID), 32'd0);
    chk("elos_c1_busy", 32'(BUSY), 32'd1);
    chk("elos_c1_ready", 32'(REQ_READY), 32'd0);
    chk("elos_c1_es_b", 32'(ES_B), 32'h8000);
    tick();
    chk("elos_c2_valid", 32'(RSP_VALID), 32'd1);
    chk("elos_c2_data", RSP_DATA, 32'hFFFF8000);
    // A request during the stall must be ignored.
    REQ_VALID = 1'b1; REQ_OP = 2'd2; REQ_IMM = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(RSP_VALID), 32'd1);
      chk("stall_data", RSP_DATA, 32'hFFFF8000);
      chk("stall_ready", 32'(REQ_READY), 32'd0);
      chk("stall_busy", 32'(BUSY), 32'd1);
    end
`ifdef ES_SEQ_PIPE_EN
    // Handshake and new accept in the same cycle: no IDLE in between.
    REQ_OP = 2'd2; REQ_IMM = 16'hABCD; RSP_READY = 1'b1;
    #1 chk("pipe_ready_on_hs", 32'(REQ_READY), 32'd1);
    tick();
    REQ_VALID = 1'b0; RSP_READY = 1'b0;
    chk("pipe_exec_valid", 32'(RSP_VALID), 32'd0);
    chk("pipe_exec_sel", 32'(ES_SEL), 32'd2);
    chk("pipe_exec_busy", 32'(BUSY), 32'd1);
    tick();
    chk("pipe_done_valid", 32'(RSP_VALID), 32'd1);
    chk("pipe_done_data", RSP_DATA, 32'hABCD0000);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk("pipe_idle_busy", 32'(BUSY), 32'd0);
`else
    // REQ_VALID still high on the handshake cycle: it must not be taken.
    RSP_READY = 1'b1;
    tick();
    REQ_VALID = 1'b0; RSP_READY = 1'b0;
    chk("hs_idle_valid", 32'(RSP_VALID), 32'd0);
    chk("hs_idle_busy", 32'(BUSY), 32'd0);
    chk("hs_idle_ready", 32'(REQ_READY), 32'd1);
    chk("hs_no_accept_sel", 32'(ES_SEL), 32'd0);
`endif

    // Extend ops
    run_op("elou", 2'd1, 32'd0, 16'h8000, 5'd0, 32'h00008000, 2, 1, 2'd1);
    run_op("ehiz", 2'd2, 32'd0, 16'h1234, 5'd0, 32'h12340000, 2, 1, 2'd2);

    // SLL by 31: 11 passes (3 x10, then 1)
    run_op("sll31", 2'd3, 32'h1, 16'd0, 5'd31, 32'h80000000, 12, 11, 2'd3);
    chk("sll31_npass", 32'(steps_q.size()), 32'd11);
    if (steps_q.size() == 11) begin
      chk("sll31_step0", 32'(steps_q[0]), 32'd3);
      chk("sll31_step9", 32'(steps_q[9]), 32'd3);
      chk("sll31_step10", 32'(steps_q[10]), 32'd1);
    end

    // SLL by 0: one pass with step 0
    run_op("sll0", 2'd3, 32'hDEADBEEF, 16'd0, 5'd0, 32'hDEADBEEF, 2, 1, 2'd3);
    chk("sll0_step", (steps_q.size() > 0) ? 32'(steps_q[0]) : 32'hFFFF_FFFF, 32'd0);

    // SLL by 4: steps 3 then 1
    run_op("sll4", 2'd3, 32'hDEADBEEF, 16'd0, 5'd4, 32'hEADBEEF0, 3, 2, 2'd3);
    chk("sll4_step0", (steps_q.size() > 1) ? 32'(steps_q[0]) : 32'hFFFF_FFFF, 32'd3);
    chk("sll4_step1", (steps_q.size() > 1) ? 32'(steps_q[1]) : 32'hFFFF_FFFF, 32'd1);

    // SLL by 30: high bits are shifted out
    run_op("sll30", 2'd3, 32'h0000000F, 16'd0, 5'd30, 32'hC0000000, 11, 10, 2'd3);

    // Reset during pass 5 of SLL by 31
    issue(2'd3, 32'h1, 16'd0, 5'd31);
    tick(); tick(); tick(); tick();
    chk("abort_pass5_es_a", ES_A, 32'h00001000);
    chk("abort_pass5_es_b", 32'(ES_B), 32'd3);
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    chk("abort_ready", 32'(REQ_READY), 32'd1);
    chk("abort_valid", 32'(RSP_VALID), 32'd0);
    chk("abort_data", RSP_DATA, 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_es_a", ES_A, 32'd0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (RSP_VALID) vcount++;
    end
    chk("abort_no_response", 32'(vcount), 32'd0);
    run_op("post_abort", 2'd1, 32'd0, 16'h7FFF, 5'd0, 32'h00007FFF, 2, 1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
